// File: rtl/mips_mc_core_if.sv
// Unified memory bus of mips_mc_core: one request/ready channel shared by
// instruction fetch and data access. The core drives the master side.
interface mips_mc_core_if #(
  parameter int ADDR_W = 12
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mips_mc_core.sv
// mips_mc_core: multi-cycle MIPS-I subset core with a single unified memory
// port. Supports addu, subu, slt, jr, ori, addiu, lui, lw, sw, beq, bne, j,
// jal; any other encoding halts the core until reset.
// Optional build macro MIPS_MC_PERF_EN adds the 32-bit 'retired' counter port.
module mips_mc_core #(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  mips_mc_core_if.master  bus,
  output logic            halted,
  output logic [31:0]     pc_out
`ifdef MIPS_MC_PERF_EN
  ,
  output logic [31:0]     retired
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC, MEMADR, MEMRD, MEMWR, WB, BRANCH, JUMP, HALT
  } state_t;

  state_t state, state_next;

  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] target;
  logic [31:0] alu_out;
  logic [31:0] mdr;
  logic [31:0] rf [32];

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] instr_index;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_result;
  logic        branch_take;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;

  logic              req_c;
  logic              we_c;
  logic [ADDR_W-1:0] addr_c;
  logic              halted_c;
  logic              retire_c;

  assign op          = ir[31:26];
  assign rs          = ir[25:21];
  assign rt          = ir[20:16];
  assign rd          = ir[15:11];
  assign funct       = ir[5:0];
  assign imm         = ir[15:0];
  assign instr_index = ir[25:0];
  assign imm_sext    = {{16{imm[15]}}, imm};
  assign imm_zext    = {16'h0000, imm};

  assign rs_val = (rs == 5'd0) ? '0 : rf[rs];
  assign rt_val = (rt == 5'd0) ? '0 : rf[rt];

  assign branch_take = (op == OP_BEQ) ? (a_reg == b_reg) : (a_reg != b_reg);
  assign wb_dst      = (op == OP_RTYPE) ? rd : rt;
  assign wb_data     = (op == OP_LW) ? mdr : alu_out;

  // ALU function selected by the latched instruction
  always_comb begin
    alu_result = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: alu_result = a_reg + b_reg;
          FN_SUBU: alu_result = a_reg - b_reg;
          FN_SLT:  alu_result = ($signed(a_reg) < $signed(b_reg)) ? 32'd1 : 32'd0;
          default: alu_result = '0;
        endcase
      end
      OP_ORI:   alu_result = a_reg | imm_zext;
      OP_ADDIU: alu_result = a_reg + imm_sext;
      OP_LUI:   alu_result = {imm, 16'h0000};
      default:  alu_result = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= state_next;
  end

  // Next-state logic and memory port control
  always_comb begin
    state_next = state;
    req_c      = 1'b0;
    we_c       = 1'b0;
    addr_c     = pc[ADDR_W-1:0];
    halted_c   = 1'b0;
    retire_c   = 1'b0;
    case (state)
      FETCH: begin
        req_c = 1'b1;
        if (bus.mem_ready) state_next = DECODE;
      end
      DECODE: begin
        case (op)
          OP_RTYPE: begin
            case (funct)
              FN_ADDU, FN_SUBU, FN_SLT: state_next = EXEC;
              FN_JR:                    state_next = JUMP;
              default:                  state_next = HALT;
            endcase
          end
          OP_ORI, OP_ADDIU, OP_LUI: state_next = EXEC;
          OP_LW, OP_SW:             state_next = MEMADR;
          OP_BEQ, OP_BNE:           state_next = BRANCH;
          OP_J, OP_JAL:             state_next = JUMP;
          default:                  state_next = HALT;
        endcase
      end
      EXEC:   state_next = WB;
      MEMADR: state_next = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD: begin
        req_c  = 1'b1;
        addr_c = alu_out[ADDR_W-1:0];
        if (bus.mem_ready) state_next = WB;
      end
      MEMWR: begin
        req_c  = 1'b1;
        we_c   = 1'b1;
        addr_c = alu_out[ADDR_W-1:0];
        if (bus.mem_ready) begin
          state_next = FETCH;
          retire_c   = 1'b1;
        end
      end
      WB, BRANCH, JUMP: begin
        state_next = FETCH;
        retire_c   = 1'b1;
      end
      HALT:    halted_c = 1'b1;
      default: state_next = FETCH;
    endcase
    // Outputs are forced idle combinationally so an in-flight access is
    // dropped the moment reset asserts, not at the next edge.
    if (!rst) begin
      req_c    = 1'b0;
      we_c     = 1'b0;
      halted_c = 1'b0;
      retire_c = 1'b0;
    end
  end

  assign bus.mem_req   = req_c;
  assign bus.mem_we    = we_c;
  assign bus.mem_addr  = addr_c & ~ADDR_W'(3);
  assign bus.mem_wdata = b_reg;
  assign halted        = halted_c;
  assign pc_out        = pc;

  // Datapath registers, updated per state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      target  <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.mem_ready) begin
            ir <= bus.mem_rdata;
            pc <= pc + 32'd4;
          end
        end
        DECODE: begin
          a_reg  <= rs_val;
          b_reg  <= rt_val;
          target <= pc + {imm_sext[29:0], 2'b00};
        end
        EXEC:   alu_out <= alu_result;
        MEMADR: alu_out <= a_reg + imm_sext;
        MEMRD:  if (bus.mem_ready) mdr <= bus.mem_rdata;
        BRANCH: if (branch_take) pc <= target;
        JUMP: begin
          if (op == OP_RTYPE) pc <= a_reg;
          else                pc <= {pc[31:28], instr_index, 2'b00};
        end
        default: ;
      endcase
    end
  end

  // Register file write port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == WB && wb_dst != 5'd0) rf[wb_dst] <= wb_data;
      else if (state == JUMP && op == OP_JAL) rf[31] <= pc;
    end
  end

`ifdef MIPS_MC_PERF_EN
  // Retired-instruction counter, bumped on each completing return to FETCH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          retired <= '0;
    else if (retire_c) retired <= retired + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mips_mc_core.sv
// Self-checking bench for mips_mc_core: a memory model with programmable
// data wait states, a store scoreboard, fetch-timing log and directed programs.
module tb_mips_mc_core;

  localparam int          AW   = 12;
  localparam logic [31:0] RPC  = 32'h0000_0200;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        halted;
  logic [31:0] pc_out;
`ifdef MIPS_MC_PERF_EN
  logic [31:0] retired;
`endif

  mips_mc_core_if #(.ADDR_W(AW)) bus ();

  mips_mc_core #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.master),
    .halted (halted),
    .pc_out (pc_out)
`ifdef MIPS_MC_PERF_EN
    ,
    .retired(retired)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic [31:0] mem     [1024];
  logic        is_code [1024];
  wr_t         exp_q   [$];
  int          fetch_cyc [$];
  logic [31:0] fetch_adr [$];

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          data_waits = 0;
  int          wait_cnt = 0;
  logic        pend = 1'b0;
  logic [AW-1:0] s_addr;
  logic        s_we;
  logic [31:0] s_wdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_op(input int rs, input int rt, input int rd, input logic [5:0] fn);
    r_op = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    i_op = {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] j_op(input logic [5:0] op, input logic [25:0] idx);
    j_op = {op, idx};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = '0;
      is_code[i] = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    mem[addr[11:2]]     = word;
    is_code[addr[11:2]] = 1'b1;
  endtask

  task automatic expect_wr(input logic [31:0] addr, input logic [31:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    exp_q.push_back(w);
  endtask

  // Cycle counter for latency measurement
  always @(posedge clk) cyc++;

  // Memory slave: answers on the falling edge, applies wait states to data
  // accesses, retires stores against the scoreboard, checks request stability
  always @(negedge clk) begin
    int idx;
    int w;
    wr_t e;
    if (!rst) begin
      bus.mem_ready = 1'b0;
      wait_cnt = 0;
      pend = 1'b0;
    end else begin
      if (pend) begin
        check_eq("hold_req", 32'(bus.mem_req), 32'd1);
        check_eq("hold_addr", 32'(bus.mem_addr), 32'(s_addr));
        check_eq("hold_we", 32'(bus.mem_we), 32'(s_we));
        check_eq("hold_wdata", bus.mem_wdata, s_wdata);
      end
      bus.mem_ready = 1'b0;
      pend = 1'b0;
      if (bus.mem_req) begin
        idx = int'(bus.mem_addr[AW-1:2]);
        w = (is_code[idx] && !bus.mem_we) ? 0 : data_waits;
        if (wait_cnt >= w) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem[idx];
          wait_cnt = 0;
          if (bus.mem_we) begin
            check_eq("wr_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check_eq("wr_addr", 32'(bus.mem_addr), e.addr);
              check_eq("wr_data", bus.mem_wdata, e.data);
            end
            mem[idx] = bus.mem_wdata;
          end else if (is_code[idx]) begin
            fetch_cyc.push_back(cyc);
            fetch_adr.push_back(32'(bus.mem_addr));
          end
        end else begin
          wait_cnt++;
          pend    = 1'b1;
          s_addr  = bus.mem_addr;
          s_we    = bus.mem_we;
          s_wdata = bus.mem_wdata;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("rst_pc", pc_out, RPC);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_req", 32'(bus.mem_req), 32'd0);
    check_eq("rst_we", 32'(bus.mem_we), 32'd0);
    fetch_cyc.delete();
    fetch_adr.delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("first_req", 32'(bus.mem_req), 32'd1);
    check_eq("first_addr", 32'(bus.mem_addr), RPC);
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    check_eq("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic check_halt_steady(input logic [31:0] exp_pc);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check_eq("halt_flag", 32'(halted), 32'd1);
      check_eq("halt_req", 32'(bus.mem_req), 32'd0);
      check_eq("halt_pc", pc_out, exp_pc);
    end
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_lat(input string tag, input logic [31:0] at, input int lat, input logic [31:0] nxt);
    int   idx;
    logic found;
    idx = -1;
    for (int i = 0; i < fetch_adr.size(); i++)
      if (idx < 0 && fetch_adr[i] == at) idx = i;
    found = (idx >= 0) && (idx + 1 < fetch_adr.size());
    check_eq({tag, "_seen"}, 32'(found), 32'd1);
    if (found) begin
      check_eq({tag, "_cycles"}, 32'(fetch_cyc[idx+1] - fetch_cyc[idx]), 32'(lat));
      check_eq({tag, "_next"}, fetch_adr[idx+1], nxt);
    end
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;

    // ALU ops, $0 discard, store path with zero wait states
    clear_mem();
    data_waits = 0;
    put(32'h200, i_op(6'h0D, 0, 1, 16'h1234));
    put(32'h204, i_op(6'h09, 0, 2, 16'hFFFF));
    put(32'h208, r_op(1, 2, 3, 6'h21));
    put(32'h20C, r_op(2, 1, 4, 6'h2A));
    put(32'h210, r_op(1, 2, 6, 6'h23));
    put(32'h214, i_op(6'h0F, 0, 7, 16'hABCD));
    put(32'h218, i_op(6'h09, 0, 0, 16'h0005));
    put(32'h21C, i_op(6'h2B, 0, 3, 16'h0800));
    put(32'h220, i_op(6'h2B, 0, 4, 16'h0804));
    put(32'h224, i_op(6'h2B, 0, 6, 16'h0808));
    put(32'h228, i_op(6'h2B, 0, 7, 16'h080C));
    put(32'h22C, i_op(6'h2B, 0, 0, 16'h0810));
    put(32'h230, HALT_W);
    expect_wr(32'h800, 32'h0000_1233);
    expect_wr(32'h804, 32'h0000_0001);
    expect_wr(32'h808, 32'h0000_1235);
    expect_wr(32'h80C, 32'hABCD_0000);
    expect_wr(32'h810, 32'h0000_0000);
    reset_dut();
    wait_halt(200);
    check_lat("ori", 32'h200, 4, 32'h204);
    check_lat("addu", 32'h208, 4, 32'h20C);
    check_lat("lui", 32'h214, 4, 32'h218);
    check_lat("sw0", 32'h21C, 4, 32'h220);
    check_halt_steady(32'h234);
`ifdef MIPS_MC_PERF_EN
    check_eq("retired_p1", retired, 32'd12);
`endif

    // Loads/stores with three wait states per data access, address wrap
    clear_mem();
    data_waits = 3;
    put(32'h200, i_op(6'h0D, 0, 1, 16'h1234));
    put(32'h204, i_op(6'h2B, 0, 1, 16'h0008));
    put(32'h208, i_op(6'h23, 0, 5, 16'h0008));
    put(32'h20C, i_op(6'h2B, 0, 5, 16'h0800));
    put(32'h210, i_op(6'h23, 0, 8, 16'h1008));
    put(32'h214, i_op(6'h2B, 0, 8, 16'h0804));
    put(32'h218, HALT_W);
    expect_wr(32'h008, 32'h0000_1234);
    expect_wr(32'h800, 32'h0000_1234);
    expect_wr(32'h804, 32'h0000_1234);
    reset_dut();
    wait_halt(300);
    check_lat("sw_wait", 32'h204, 7, 32'h208);
    check_lat("lw_wait", 32'h208, 8, 32'h20C);
    check_halt_steady(32'h21C);

    // beq taken, bne not taken
    clear_mem();
    data_waits = 0;
    put(32'h200, i_op(6'h0D, 0, 1, 16'h0005));
    put(32'h204, i_op(6'h0D, 0, 2, 16'h0005));
    put(32'h208, i_op(6'h04, 1, 2, 16'h0002));
    put(32'h20C, HALT_W);
    put(32'h210, HALT_W);
    put(32'h214, i_op(6'h05, 1, 2, 16'h0005));
    put(32'h218, i_op(6'h0D, 0, 3, 16'h0077));
    put(32'h21C, i_op(6'h2B, 0, 3, 16'h0800));
    put(32'h220, HALT_W);
    expect_wr(32'h800, 32'h0000_0077);
    reset_dut();
    wait_halt(200);
    check_lat("beq", 32'h208, 3, 32'h214);
    check_lat("bne", 32'h214, 3, 32'h218);
    check_halt_steady(32'h224);

    // j / jal / jr, then reset pulse out of HALT
    clear_mem();
    put(32'h200, j_op(6'h02, 26'h000_0004));
    put(32'h010, j_op(6'h03, 26'h000_0040));
    put(32'h100, i_op(6'h2B, 0, 31, 16'h0800));
    put(32'h104, r_op(31, 0, 0, 6'h08));
    put(32'h014, HALT_W);
    expect_wr(32'h800, 32'h0000_0014);
    reset_dut();
    wait_halt(200);
    check_lat("j", 32'h200, 3, 32'h010);
    check_lat("jal", 32'h010, 3, 32'h100);
    check_lat("jr", 32'h104, 3, 32'h014);
    check_halt_steady(32'h018);
    clear_mem();
    put(32'h200, HALT_W);
    reset_dut();
    wait_halt(50);
    check_halt_steady(32'h204);

    // Reset asserted while a store is stalled
    clear_mem();
    data_waits = 10;
    put(32'h200, i_op(6'h0D, 0, 1, 16'h0055));
    put(32'h204, i_op(6'h2B, 0, 1, 16'h0800));
    put(32'h208, HALT_W);
    reset_dut();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_we) break;
    end
    check_eq("st_stalled", 32'(bus.mem_req && bus.mem_we), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("abort_req", 32'(bus.mem_req), 32'd0);
    check_eq("abort_we", 32'(bus.mem_we), 32'd0);
    check_eq("abort_pc", pc_out, RPC);
`ifdef MIPS_MC_PERF_EN
    check_eq("abort_retired", retired, 32'd0);
`endif
    fetch_cyc.delete();
    fetch_adr.delete();
    expect_wr(32'h800, 32'h0000_0055);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("restart_req", 32'(bus.mem_req), 32'd1);
    check_eq("restart_addr", 32'(bus.mem_addr), RPC);
    wait_halt(200);
    check_halt_steady(32'h20C);
`ifdef MIPS_MC_PERF_EN
    check_eq("retired_p5", retired, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_mc_core.md
MIPS_MC_CORE -- requirements
Module: mips_mc_core

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, byte-address width driven on mem_addr (4 KiB space).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mem_req  out  1  memory access request (fetch or data).
REQ-006 SHALL have port mem_we  out  1  1 = write (sw), 0 = read; valid only while mem_req=1.
REQ-007 SHALL have port mem_addr  out  ADDR_W  byte address, word-aligned (bits [1:0] = 0).
REQ-008 SHALL have port mem_wdata  out  32  store data.
REQ-009 SHALL have port mem_rdata  in  32  read data, sampled in the cycle where mem_ready=1.
REQ-010 SHALL have port mem_ready  in  1  access completes in the cycle where mem_req=1 and mem_ready=1.
REQ-011 SHALL have port halted  out  1  core stopped on unsupported opcode.
REQ-012 SHALL have port pc_out  out  32  current PC.

Function
REQ-013 SHALL implement a single unified memory port shared by fetch and data access; mem_req, mem_we, mem_addr and mem_wdata SHALL remain stable until mem_ready=1, and any number of wait cycles SHALL be tolerated.
REQ-014 SHALL support addu, subu, slt, jr (R-type); ori, addiu, lui, lw, sw, beq, bne, j, jal, all with standard MIPS-I encodings.
REQ-015 SHALL hold a 32x32 register file internally; $0 reads 0 and writes to it are discarded.
REQ-016 SHALL use FSM states FETCH, DECODE, EXEC, MEMADR, MEMRD, MEMWR, WB, BRANCH, JUMP, HALT.
REQ-017 FETCH: drive mem_req=1, mem_we=0, mem_addr=PC[ADDR_W-1:0]; on mem_ready, latch IR, set PC<=PC+4, go to DECODE; otherwise stay in FETCH.
REQ-018 DECODE: latch rs/rt operands and branch target PC+(sext(imm)<<2); go to EXEC (R-type, ori, addiu, lui), MEMADR (lw/sw), BRANCH (beq/bne), JUMP (j/jal/jr), or HALT (any other opcode/funct).
REQ-019 EXEC->WB: WB writes rd (R-type) or rt (I-type), then goes to FETCH; ori and lui zero-extend imm, addiu sign-extends; slt is a signed compare producing 0 or 1; no overflow traps.
REQ-020 MEMADR computes rs+sext(imm) and goes to MEMRD (lw) or MEMWR (sw); MEMRD holds the read until mem_ready, then goes to WB (writes rt); MEMWR holds the write with mem_wdata=rt until mem_ready, then goes to FETCH.
REQ-021 BRANCH: beq takes the branch when rs==rt, bne when rs!=rt; a taken branch loads PC<=target; next state FETCH.
REQ-022 JUMP: j/jal load PC<={PC[31:28],instr_index,2'b00}; jal also writes $31<=PC (already +4); jr loads PC<=rs; next state FETCH.
REQ-023 Latencies with mem_ready tied to 1 SHALL be: R-type and I-ALU 4 cycles, lw 5, sw 4, branch 3, jump 3; each wait cycle adds 1.
REQ-024 HALT SHALL be terminal: halted=1, mem_req=0, PC frozen until reset.
REQ-025 Memory address bits above ADDR_W SHALL be ignored (wrap-around); PC increments modulo 2^32.

Reset
REQ-026 While rst=0: state=FETCH, PC=RESET_PC, mem_req=0, mem_we=0, halted=0, pc_out=RESET_PC; register-file contents are not reset.
REQ-027 Reset asserted mid-access SHALL abandon the access immediately, with no register or PC update; after release, the first cycle SHALL be FETCH at RESET_PC.

Configuration
REQ-028 With macro MIPS_MC_PERF_EN defined, the core SHALL add output retired (32-bit), reset to 0 and incremented by 1 on each instruction's final state transition back to FETCH (not on HALT); without the macro the port and its counter SHALL be absent.

Verification
REQ-029 Directed tests SHALL cover:
- ori $1,$0,0x1234; addiu $2,$0,-1; addu $3,$1,$2 -> $3=0x1233; slt $4,$2,$1 -> $4=1.
- sw $1,8($0) then lw $5,8($0) with 3 wait cycles per access -> $5=0x1234; signals held stable while waiting; lw takes 8 cycles.
- beq taken (equal operands) and bne not taken -> PC is target and PC+4 respectively, each after 3 cycles.
- jal 0x40 at PC 0x10 -> $31=0x14 and PC=0x100; then jr $31 -> PC=0x14.
- Opcode 6'h3F -> halted=1, mem_req=0 indefinitely; rst pulse -> fetch resumes at RESET_PC.
- Reset asserted during a MEMWR wait -> mem_req drops asynchronously; with MIPS_MC_PERF_EN, retired=0 after reset.
